// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite-attribute DMA engine with CPU passthrough while idle
// Optional macro OAM_DMA_ADDR_RELOAD_EN: rewrite $2003 with idx before every byte.
`timescale 1ns/1ps
module oam_dma (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_write_en,
    input  logic        cpu_read_en,
    output logic        cpu_halt,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_data_out,
    output logic        mem_write_en,
    output logic        mem_read_en,
    input  logic [7:0]  mem_data_in,
    input  logic        mem_busy,
    output logic        dma_active,
    output logic        dma_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETADDR,
        S_READ,
        S_LATCH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] page_q, page_d;
    logic [7:0] byte_reg_q, byte_reg_d;
    logic       trigger;

    assign trigger = cpu_write_en && (cpu_addr == 16'h4014);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 8'h00;
            page_q     <= 8'h00;
            byte_reg_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            page_q     <= page_d;
            byte_reg_q <= byte_reg_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        page_d       = page_q;
        byte_reg_d   = byte_reg_q;
        mem_addr     = 16'h0000;
        mem_data_out = 8'h00;
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        dma_done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                mem_addr     = cpu_addr;
                mem_data_out = cpu_data;
                mem_read_en  = cpu_read_en;
                mem_write_en = cpu_write_en && !trigger;
                if (trigger) begin
                    page_d  = cpu_data;
                    idx_d   = 8'h00;
                    state_d = S_SETADDR;
                end
            end
            S_SETADDR: begin
                mem_addr     = 16'h2003;
                mem_data_out = idx_q;
                mem_write_en = 1'b1;
                state_d      = S_READ;
            end
            S_READ: begin
                mem_addr    = {page_q, idx_q};
                mem_read_en = 1'b1;
                state_d     = S_LATCH;
            end
            S_LATCH: begin
                // Memory controller registered the byte on the edge that ended READ.
                mem_addr   = {page_q, idx_q};
                byte_reg_d = mem_data_in;
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                mem_addr     = 16'h2004;
                mem_data_out = byte_reg_q;
                mem_write_en = 1'b1;
                if (idx_q == 8'hFF) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 8'h01;
`ifdef OAM_DMA_ADDR_RELOAD_EN
                    state_d = S_SETADDR;
`else
                    state_d = S_READ;
`endif
                end
            end
            S_DONE: begin
                dma_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A busy memory controller freezes the transfer; outputs repeat unchanged.
        if ((state_q != S_IDLE) && mem_busy) begin
            state_d    = state_q;
            idx_d      = idx_q;
            page_d     = page_q;
            byte_reg_d = byte_reg_q;
        end
    end

    assign cpu_halt   = (state_q != S_IDLE);
    assign dma_active = cpu_halt;

endmodule
